// File: rtl/l2_array_pkg.sv
// Shared types and helpers for the L2 multi-way tag/metadata array.
// Latency: n/a (package).  Backpressure: n/a.
// Contents: sweep FSM state encoding, flattened-vector way offset helper.
package l2_array_pkg;

    typedef enum logic {
        SW_IDLE  = 1'b0,
        SW_SWEEP = 1'b1
    } sweep_state_t;

    // Low bit of way w inside a num_ways*wdt flattened vector.
    function automatic int way_slice(input int w, input int wdt);
        return w * wdt;
    endfunction

endpackage

// File: rtl/l2_way_bank.sv
// One way of the L2 array: per-set data + valid, with load, set-invalidate and sweep-clear.
// Latency: registered read 1 cycle (with write-through bypass); imm read 0 cycles (stored state only).
// Backpressure: none; the caller gates ops while a sweep runs.
// Ports: clk/rst; read+rindex (read request); load/inv_set at windex; sweep_clr at sweep_index;
//        datain; dataout/valid_out (registered); dataout_imm/valid_imm (combinational).
module l2_way_bank
    import l2_array_pkg::*;
#(
    parameter int s_index = 4,
    parameter int width   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic [s_index-1:0] rindex,
    input  logic               load,
    input  logic               inv_set,
    input  logic [s_index-1:0] windex,
    input  logic               sweep_clr,
    input  logic [s_index-1:0] sweep_index,
    input  logic [width-1:0]   datain,
    output logic [width-1:0]   dataout,
    output logic               valid_out,
    output logic [width-1:0]   dataout_imm,
    output logic               valid_imm
);

    localparam int NUM_SETS = 2 ** s_index;

    logic [width-1:0]    data_q [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;

    logic same_set;
    assign same_set = (rindex == windex);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                data_q[i] <= '0;
            end
            valid_q   <= '0;
            dataout   <= '0;
            valid_out <= 1'b0;
        end else begin
            // Load beats a same-cycle set invalidate for this way.
            if (load) begin
                data_q[windex]  <= datain;
                valid_q[windex] <= 1'b1;
            end else if (inv_set) begin
                valid_q[windex] <= 1'b0;
            end
            if (sweep_clr) begin
                valid_q[sweep_index] <= 1'b0;
            end
            // Registered read sees this cycle's write/invalidate on the same set.
            if (read) begin
                if (load && same_set) begin
                    dataout   <= datain;
                    valid_out <= 1'b1;
                end else begin
                    dataout   <= data_q[rindex];
                    valid_out <= valid_q[rindex] & ~(inv_set && same_set);
                end
            end
        end
    end

    assign dataout_imm = data_q[rindex];
    assign valid_imm   = valid_q[rindex];

endmodule

// File: rtl/l2_multiway_array.sv
// N-way L2 tag/metadata array with per-way load, single-set invalidate and whole-array valid sweep.
// Latency: registered read 1 cycle; imm outputs combinational; sweep takes num_sets cycles.
// Backpressure: busy high during sweep; read/load/inv_set/inv_all are dropped while busy.
// Ports: clk/rst; read, rindex; load[num_ways], windex, datain; inv_set; inv_all; busy;
//        dataout/valid_out (registered, way w at [w*width +: width]); dataout_imm/valid_imm.
module l2_multiway_array
    import l2_array_pkg::*;
#(
    parameter int s_index  = 4,
    parameter int width    = 24,
    parameter int num_ways = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        read,
    input  logic [s_index-1:0]          rindex,
    input  logic [num_ways-1:0]         load,
    input  logic [s_index-1:0]          windex,
    input  logic [width-1:0]            datain,
    input  logic                        inv_set,
    input  logic                        inv_all,
    output logic                        busy,
    output logic [num_ways*width-1:0]   dataout,
    output logic [num_ways-1:0]         valid_out,
    output logic [num_ways*width-1:0]   dataout_imm,
    output logic [num_ways-1:0]         valid_imm
);

    sweep_state_t       state, state_nxt;
    logic [s_index-1:0] ptr, ptr_nxt;
    logic               sweep_clr;
    logic               op_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SW_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // ptr is all-ones exactly on the last set, so &ptr marks sweep exit.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sweep_clr = 1'b0;
        case (state)
            SW_IDLE: begin
                if (inv_all) begin
                    state_nxt = SW_SWEEP;
                    ptr_nxt   = '0;
                end
            end
            SW_SWEEP: begin
                sweep_clr = 1'b1;
                if (&ptr) begin
                    state_nxt = SW_IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            default: state_nxt = SW_IDLE;
        endcase
    end

    assign busy  = (state == SW_SWEEP);
    assign op_en = ~busy;

    for (genvar w = 0; w < num_ways; w++) begin : g_way
        localparam int LO = way_slice(w, width);

        l2_way_bank #(
            .s_index (s_index),
            .width   (width)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .read        (read & op_en),
            .rindex      (rindex),
            .load        (load[w] & op_en),
            .inv_set     (inv_set & op_en),
            .windex      (windex),
            .sweep_clr   (sweep_clr),
            .sweep_index (ptr),
            .datain      (datain),
            .dataout     (dataout[LO +: width]),
            .valid_out   (valid_out[w]),
            .dataout_imm (dataout_imm[LO +: width]),
            .valid_imm   (valid_imm[w])
        );
    end

endmodule

// File: tb/tb_l2_multiway_array.sv
module tb_l2_multiway_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [3:0]  rindex;
    logic [3:0]  load;
    logic [3:0]  windex;
    logic [23:0] datain;
    logic        inv_set;
    logic        inv_all;
    logic        busy;
    logic [95:0] dataout;
    logic [3:0]  valid_out;
    logic [95:0] dataout_imm;
    logic [3:0]  valid_imm;

    int n_checks = 0;
    int n_fail   = 0;

    l2_multiway_array #(.s_index(4), .width(24), .num_ways(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .read        (read),
        .rindex      (rindex),
        .load        (load),
        .windex      (windex),
        .datain      (datain),
        .inv_set     (inv_set),
        .inv_all     (inv_all),
        .busy        (busy),
        .dataout     (dataout),
        .valid_out   (valid_out),
        .dataout_imm (dataout_imm),
        .valid_imm   (valid_imm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ops();
        read = 0; load = 4'b0; inv_set = 0; inv_all = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_ops(); rindex = 0; windex = 0; datain = 0;
        tick(); tick();
        rst = 0; read = 1; rindex = 4'd3;
        tick();
        read = 0;
        n_checks++; if (dataout !== 96'h0) begin n_fail++; $display("FAIL reset_dataout got %h want 0", dataout); end
        n_checks++; if (valid_out !== 4'b0) begin n_fail++; $display("FAIL reset_valid_out got %b want 0000", valid_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_write_read();
        logic [95:0] exp_d;
        exp_d = '0;
        exp_d[0 +: 24]  = 24'h0ABCDE;
        exp_d[48 +: 24] = 24'h0ABCDE;
        idle_ops();
        load = 4'b0101; windex = 4'd5; datain = 24'h0ABCDE;
        tick();
        load = 4'b0; read = 1; rindex = 4'd5;
        #1;
        n_checks++; if (valid_imm !== 4'b0101) begin n_fail++; $display("FAIL wr_valid_imm got %b want 0101", valid_imm); end
        n_checks++; if (dataout_imm !== exp_d) begin n_fail++; $display("FAIL wr_dataout_imm got %h want %h", dataout_imm, exp_d); end
        tick();
        read = 0;
        n_checks++; if (valid_out !== 4'b0101) begin n_fail++; $display("FAIL wr_valid_out got %b want 0101", valid_out); end
        n_checks++; if (dataout !== exp_d) begin n_fail++; $display("FAIL wr_dataout got %h want %h", dataout, exp_d); end
        // read low: registered outputs hold even though rindex moves
        rindex = 4'd3;
        tick();
        n_checks++; if (dataout !== exp_d) begin n_fail++; $display("FAIL hold_dataout got %h want %h", dataout, exp_d); end
        n_checks++; if (valid_out !== 4'b0101) begin n_fail++; $display("FAIL hold_valid_out got %b want 0101", valid_out); end
    endtask

    task automatic test_bypass();
        idle_ops();
        read = 1; rindex = 4'd7; windex = 4'd7; load = 4'b1000; datain = 24'h123456;
        #1;
        n_checks++; if (valid_imm !== 4'b0000) begin n_fail++; $display("FAIL byp_imm_no_bypass got %b want 0000", valid_imm); end
        tick();
        idle_ops();
        n_checks++; if (dataout[72 +: 24] !== 24'h123456) begin n_fail++; $display("FAIL byp_way3 got %h want 123456", dataout[72 +: 24]); end
        n_checks++; if (valid_out !== 4'b1000) begin n_fail++; $display("FAIL byp_valid_out got %b want 1000", valid_out); end
        n_checks++; if (dataout[0 +: 24] !== 24'h0) begin n_fail++; $display("FAIL byp_way0 got %h want 0", dataout[0 +: 24]); end
    endtask

    task automatic test_inv_load();
        idle_ops();
        load = 4'b1111; windex = 4'd2; datain = 24'h111111;
        tick();
        load = 4'b0010; datain = 24'h222222; inv_set = 1; read = 1; rindex = 4'd2;
        tick();
        load = 4'b0; inv_set = 0;
        n_checks++; if (valid_out !== 4'b0010) begin n_fail++; $display("FAIL invld_byp_valid got %b want 0010", valid_out); end
        n_checks++; if (dataout[24 +: 24] !== 24'h222222) begin n_fail++; $display("FAIL invld_byp_way1 got %h want 222222", dataout[24 +: 24]); end
        n_checks++; if (dataout[0 +: 24] !== 24'h111111) begin n_fail++; $display("FAIL invld_byp_way0 got %h want 111111", dataout[0 +: 24]); end
        tick();
        read = 0;
        n_checks++; if (valid_out !== 4'b0010) begin n_fail++; $display("FAIL invld_stored_valid got %b want 0010", valid_out); end
        n_checks++; if (dataout[24 +: 24] !== 24'h222222) begin n_fail++; $display("FAIL invld_stored_way1 got %h want 222222", dataout[24 +: 24]); end
    endtask

    task automatic test_sweep();
        int          cyc;
        logic [23:0] d;
        idle_ops();
        for (int s = 0; s < 16; s++) begin
            load = 4'b1111; windex = s[3:0]; datain = 24'hA00000 + 24'(s);
            tick();
        end
        load = 4'b0; read = 1; rindex = 4'd4;
        tick();
        read = 0;
        inv_all = 1;
        tick();
        inv_all = 0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            // ops issued while busy must be dropped
            read = 1; rindex = 4'd9; load = 4'b1111; windex = 4'd9; datain = 24'hFFFFFF;
            inv_set = 1; inv_all = 1;
            tick();
        end
        idle_ops();
        n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL sweep_busy_cycles got %0d want 16", cyc); end
        n_checks++; if (dataout !== {4{24'hA00004}}) begin n_fail++; $display("FAIL sweep_hold_dataout got %h want %h", dataout, {4{24'hA00004}}); end
        n_checks++; if (valid_out !== 4'b1111) begin n_fail++; $display("FAIL sweep_hold_valid got %b want 1111", valid_out); end
        for (int s = 0; s < 16; s++) begin
            rindex = s[3:0];
            d = 24'hA00000 + 24'(s);
            #1;
            n_checks++; if (valid_imm !== 4'b0) begin n_fail++; $display("FAIL sweep_valid_set%0d got %b want 0000", s, valid_imm); end
            n_checks++; if (dataout_imm !== {4{d}}) begin n_fail++; $display("FAIL sweep_data_set%0d got %h want %h", s, dataout_imm, {4{d}}); end
        end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sweep_no_restart got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        idle_ops();
        load = 4'b1111; windex = 4'd0; datain = 24'hB00000;
        tick();
        windex = 4'd15;
        tick();
        load = 4'b0; inv_all = 1;
        tick();
        inv_all = 0;
        cyc = 1;
        while (busy === 1'b1 && cyc < 6) begin
            tick();
            cyc++;
        end
        rst = 1;
        tick();
        rst = 0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        rindex = 4'd15; #1;
        n_checks++; if (valid_imm !== 4'b0) begin n_fail++; $display("FAIL rstmid_valid15 got %b want 0000", valid_imm); end
        n_checks++; if (dataout_imm !== 96'h0) begin n_fail++; $display("FAIL rstmid_data15 got %h want 0", dataout_imm); end
        n_checks++; if (valid_out !== 4'b0) begin n_fail++; $display("FAIL rstmid_valid_out got %b want 0000", valid_out); end
        // restart: set 0 must clear on the first sweep step, set 15 still valid
        load = 4'b1111; windex = 4'd0; datain = 24'hC00000;
        tick();
        windex = 4'd15;
        tick();
        load = 4'b0; inv_all = 1;
        tick();
        inv_all = 0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", busy); end
        tick();
        rindex = 4'd0; #1;
        n_checks++; if (valid_imm !== 4'b0) begin n_fail++; $display("FAIL restart_set0 got %b want 0000", valid_imm); end
        rindex = 4'd15; #1;
        n_checks++; if (valid_imm !== 4'b1111) begin n_fail++; $display("FAIL restart_set15 got %b want 1111", valid_imm); end
        cyc = 2;
        while (busy === 1'b1 && cyc < 40) begin
            tick();
            if (busy === 1'b1) cyc++;
        end
        n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL restart_busy_cycles got %0d want 16", cyc); end
        n_checks++; if (valid_imm !== 4'b0) begin n_fail++; $display("FAIL restart_set15_final got %b want 0000", valid_imm); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_inv_load();
        test_sweep();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
